// File: rtl/lisnoc_mp_simple_arbiter.sv
// Round-robin arbiter sharing one size-then-flits message endpoint between bus masters.
// Send and receive messages are locked to one master until all flits have been transferred.
module lisnoc_mp_simple_arbiter #(
  parameter int masters        = 2,
  parameter int noc_data_width = 32,
  parameter int size_width     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [6*masters-1:0]               m_addr,
  input  logic [masters-1:0]                 m_we,
  input  logic [masters-1:0]                 m_en,
  input  logic [noc_data_width*masters-1:0]  m_data_in,
  output logic [noc_data_width-1:0]          m_data_out,
  output logic [masters-1:0]                 m_ack,
  output logic [5:0]                         s_addr,
  output logic                               s_we,
  output logic                               s_en,
  output logic [noc_data_width-1:0]          s_data_in,
  input  logic [noc_data_width-1:0]          s_data_out,
  input  logic                               s_ack,
  output logic                               tx_locked,
  output logic                               rx_locked,
  output logic [$clog2(masters)-1:0]         tx_owner,
  output logic [$clog2(masters)-1:0]         rx_owner,
  output logic [size_width:0]                tx_remaining
);

  localparam int IW = $clog2(masters);
  localparam int CW = size_width + 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          hold_vld_q, hold_vld_d;
  logic [IW-1:0] hold_idx_q, hold_idx_d;
  logic          tx_locked_q, tx_locked_d;
  logic [IW-1:0] tx_owner_q, tx_owner_d;
  logic [CW-1:0] tx_rem_q, tx_rem_d;
  logic          rx_locked_q, rx_locked_d;
  logic [IW-1:0] rx_owner_q, rx_owner_d;
  logic [CW-1:0] rx_rem_q, rx_rem_d;

  logic [masters-1:0] is_st;
  logic [masters-1:0] is_tx;
  logic [masters-1:0] is_rx;
  logic [masters-1:0] tx_ok;
  logic [masters-1:0] rx_ok;
  logic [masters-1:0] elig;

  logic [IW-1:0] sel;
  logic          sel_vld;
  logic          sel_tx;
  logic          sel_rx;
  logic          fire;

  logic [size_width-1:0] tx_size;
  logic [size_width-1:0] rx_size;

  function automatic logic [IW-1:0] wrap(input int v);
    if (v >= masters) begin
      return IW'(v - masters);
    end
    return IW'(v);
  endfunction

  always_comb begin
    is_st = '0;
    is_tx = '0;
    is_rx = '0;
    tx_ok = '0;
    rx_ok = '0;
    elig  = '0;
    for (int i = 0; i < masters; i++) begin
      is_st[i] = !m_we[i] && m_addr[6*i+4];
      is_tx[i] = m_we[i];
      is_rx[i] = !m_we[i] && !m_addr[6*i+4];
      tx_ok[i] = !tx_locked_q || (tx_owner_q == IW'(i));
      rx_ok[i] = !rx_locked_q || (rx_owner_q == IW'(i));
      elig[i]  = m_en[i] && (is_st[i] ||
                 (is_tx[i] && tx_ok[i]) ||
                 (is_rx[i] && rx_ok[i]));
    end
  end

  // A stalled access keeps the bus until the endpoint acks it.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (hold_vld_q) begin
      sel     = hold_idx_q;
      sel_vld = m_en[hold_idx_q];
    end else begin
      for (int k = 0; k < masters; k++) begin
        if (!sel_vld && elig[wrap(int'(rr_ptr_q) + k)]) begin
          sel     = wrap(int'(rr_ptr_q) + k);
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign sel_tx  = is_tx[sel];
  assign sel_rx  = is_rx[sel];
  assign fire    = sel_vld && s_ack;
  assign tx_size = s_data_in[size_width-1:0];
  assign rx_size = s_data_out[size_width-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      hold_vld_q  <= 1'b0;
      hold_idx_q  <= '0;
      tx_locked_q <= 1'b0;
      tx_owner_q  <= '0;
      tx_rem_q    <= '0;
      rx_locked_q <= 1'b0;
      rx_owner_q  <= '0;
      rx_rem_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      hold_vld_q  <= hold_vld_d;
      hold_idx_q  <= hold_idx_d;
      tx_locked_q <= tx_locked_d;
      tx_owner_q  <= tx_owner_d;
      tx_rem_q    <= tx_rem_d;
      rx_locked_q <= rx_locked_d;
      rx_owner_q  <= rx_owner_d;
      rx_rem_q    <= rx_rem_d;
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    hold_vld_d  = sel_vld && !s_ack;
    hold_idx_d  = sel;
    tx_locked_d = tx_locked_q;
    tx_owner_d  = tx_owner_q;
    tx_rem_d    = tx_rem_q;
    rx_locked_d = rx_locked_q;
    rx_owner_d  = rx_owner_q;
    rx_rem_d    = rx_rem_q;

    if (fire) begin
      rr_ptr_d = wrap(int'(sel) + 1);
    end

    // A size field of zero encodes the maximum packet length.
    if (fire && sel_tx) begin
      if (!tx_locked_q) begin
        tx_locked_d = 1'b1;
        tx_owner_d  = sel;
        if (tx_size == '0) begin
          tx_rem_d = {1'b1, {size_width{1'b0}}};
        end else begin
          tx_rem_d = {1'b0, tx_size};
        end
      end else begin
        tx_rem_d = tx_rem_q - CW'(1);
        if (tx_rem_q == CW'(1)) begin
          tx_locked_d = 1'b0;
        end
      end
    end

    // An empty receive queue reports size zero: nothing to lock.
    if (fire && sel_rx) begin
      if (!rx_locked_q) begin
        rx_rem_d = {1'b0, rx_size};
        if (rx_size != '0) begin
          rx_locked_d = 1'b1;
          rx_owner_d  = sel;
        end
      end else begin
        rx_rem_d = rx_rem_q - CW'(1);
        if (rx_rem_q == CW'(1)) begin
          rx_locked_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    s_en         = sel_vld;
    s_addr       = m_addr[6*int'(sel) +: 6];
    s_we         = m_we[sel];
    s_data_in    = m_data_in[noc_data_width*int'(sel) +: noc_data_width];
    m_data_out   = s_data_out;
    m_ack        = '0;
    for (int i = 0; i < masters; i++) begin
      m_ack[i] = fire && (sel == IW'(i));
    end
    tx_locked    = tx_locked_q;
    rx_locked    = rx_locked_q;
    tx_owner     = tx_owner_q;
    rx_owner     = rx_owner_q;
    tx_remaining = tx_rem_q;
  end

endmodule
